// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped branch target buffer with 2-bit saturating
//                counters. It looks up the fetch PC combinationally and is
//                trained from EX with resolved jump/branch outcomes. Table
//                storage is not reset. Instead, a sequencer clears one valid
//                bit per cycle after reset or on a clear request.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   clock, all state updates on rising edge
//    rst_n        in   1   asynchronous active-low reset
//    clear_i      in   1   request full table invalidation (pulse)
//    busy_o       out  1   high while the invalidation sweep runs
//    if_pc_i      in  32   fetch PC to look up
//    pred_jump_o  out  1   predicted taken for if_pc_i
//    pred_addr_o  out 32   predicted target for if_pc_i (0 on miss)
//    upd_en_i     in   1   resolved, non-flushed jump/branch from EX
//    upd_pc_i     in  32   PC of the resolved instruction
//    upd_taken_i  in   1   resolved direction (1 = jumped)
//    upd_target_i in  32   resolved target address
// ============================================================================
module branch_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  output logic        busy_o,
  input  logic [31:0] if_pc_i,
  output logic        pred_jump_o,
  output logic [31:0] pred_addr_o,
  input  logic        upd_en_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  localparam logic [INDEX_BITS-1:0] SIDX_LAST = '1;

  // Sequencer state
  logic [0:0]            state_q, state_d;
  logic [INDEX_BITS-1:0] sidx_q,  sidx_d;

  // Table storage (no reset; valid bits are cleared by the sweep)
  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [31:0]           target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  // Lookup side
  logic [INDEX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0]   w_if_tag;
  logic                  w_if_hit;

  // Update side
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0]   w_upd_tag;
  logic                  w_upd_hit;
  logic                  w_upd_we;
  logic                  w_alloc;
  logic                  w_train;
  logic [1:0]            w_ctr_next;

  // The two byte-offset bits of each PC never address the table.
  logic                  w_unused;
  assign w_unused = ^{if_pc_i[1:0], upd_pc_i[1:0]};

  assign w_if_idx  = if_pc_i[INDEX_BITS+1:2];
  assign w_if_tag  = if_pc_i[31:INDEX_BITS+2];
  assign w_if_hit  = valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);

  assign w_upd_idx = upd_pc_i[INDEX_BITS+1:2];
  assign w_upd_tag = upd_pc_i[31:INDEX_BITS+2];
  assign w_upd_hit = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == w_upd_tag);

  // A clear in the same cycle as an update wins; the update is dropped.
  assign w_upd_we  = (state_q == S_READY) && upd_en_i && !clear_i;
  assign w_alloc   = w_upd_we && !w_upd_hit && upd_taken_i;
  assign w_train   = w_upd_we && w_upd_hit;

  // Saturating 2-bit counter step
  always_comb begin
    w_ctr_next = ctr_q[w_upd_idx];
    if (upd_taken_i) begin
      if (ctr_q[w_upd_idx] != 2'd3) w_ctr_next = ctr_q[w_upd_idx] + 2'd1;
    end else begin
      if (ctr_q[w_upd_idx] != 2'd0) w_ctr_next = ctr_q[w_upd_idx] - 2'd1;
    end
  end

  // ---------------------------------------------------------------- FSM ---
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      sidx_q  <= '0;
    end else begin
      state_q <= state_d;
      sidx_q  <= sidx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    sidx_d  = sidx_q;
    case (state_q)
      S_INIT: begin
        if (clear_i) begin
          sidx_d = '0;
        end else if (sidx_q == SIDX_LAST) begin
          state_d = S_READY;
          sidx_d  = '0;
        end else begin
          sidx_d = sidx_q + 1'b1;
        end
      end
      S_READY: begin
        if (clear_i) begin
          state_d = S_INIT;
          sidx_d  = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        sidx_d  = '0;
      end
    endcase
  end

  // Output logic: predictions are suppressed while the table is unreliable.
  always_comb begin
    busy_o      = (state_q == S_INIT);
    pred_jump_o = 1'b0;
    pred_addr_o = 32'h0;
    if (state_q == S_READY && w_if_hit) begin
      pred_jump_o = ctr_q[w_if_idx][1];
      pred_addr_o = target_q[w_if_idx];
    end
  end

  // ------------------------------------------------------------ storage ---
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      valid_q[sidx_q] <= 1'b0;
    end else if (w_alloc) begin
      valid_q[w_upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      tag_q[w_upd_idx]    <= w_upd_tag;
      target_q[w_upd_idx] <= upd_target_i;
      ctr_q[w_upd_idx]    <= 2'd2;
    end else if (w_train) begin
      ctr_q[w_upd_idx] <= w_ctr_next;
      if (upd_taken_i) target_q[w_upd_idx] <= upd_target_i;
    end
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating counters.
- Sits in IF: looks up the fetch PC and produces the jump/target prediction that travels down the pipe to the EX jump-resolution logic.
- Trained from EX with the resolved outcome of each jump or branch.
- Table storage is non-resettable. A sequencer invalidates it one entry per cycle after reset or on request.

Parameters:
INDEX_BITS, 4, table has 2^INDEX_BITS entries, indexed by pc[INDEX_BITS+1:2]
TAG_BITS, 30-INDEX_BITS, derived (localparam): tag = pc[31:INDEX_BITS+2]

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  request full table invalidation (one-cycle pulse)
busy  out  1  1 while invalidation sweep runs
if_pc  in  32  fetch PC to look up
pred_jump  out  1  predicted taken for if_pc
pred_addr  out  32  predicted target for if_pc
upd_en  in  1  EX has a resolved, non-flushed jump/branch this cycle
upd_pc  in  32  PC of resolved instruction
upd_taken  in  1  resolved direction (1 = jumped)
upd_target  in  32  resolved target address

Behaviour:
- Entry contents: valid(1), tag(TAG_BITS), target(32), ctr(2). Only the valid bits must be cleared. Tag, target and ctr may be plain memory.
- FSM states: INIT, READY. Sweep index sidx is INDEX_BITS wide.
- Reset (rst_n=0, asynchronous): state=INIT, sidx=0, busy=1.
- INIT, each cycle: valid[sidx] cleared, sidx increments.
  - When sidx = 2^INDEX_BITS-1 is written, next state is READY and busy=0.
  - The sweep takes exactly 2^INDEX_BITS cycles after reset release.
- READY with clear=1: next state INIT, sidx=0.
- clear during INIT: restarts the sweep at sidx=0.
- Reset asserted mid-sweep: aborts and restarts from sidx=0 on release.
- In INIT: pred_jump=0, pred_addr=0 and upd_en is ignored (no write).
- Lookup (combinational, READY only):
  - hit = valid[idx] && tag[idx]==if_pc tag field.
  - pred_jump = hit && ctr[idx][1].
  - pred_addr = hit ? target[idx] : 32'h0.
- Update (READY, upd_en=1, written at the rising edge), using the index/tag of upd_pc:
  - Hit, taken: ctr = min(ctr+1, 3); target = upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate. valid=1, tag written, target=upd_target, ctr=2 (weakly taken). Any aliasing entry is replaced.
  - Miss, not taken: no change.
- No bypass: a lookup in the same cycle as an update to the same index sees the pre-update entry. The new value is visible the following cycle.
- A clear in the same cycle as upd_en in READY: clear wins; the update is dropped.
- Output values during reset: busy=1, pred_jump=0, pred_addr=0.

Test Plan:
- Release rst_n with INDEX_BITS=4 -> busy=1 for exactly 16 cycles, pred_jump=0 throughout, busy=0 at cycle 16. upd_en pulsed during the sweep leaves no entry.
- READY. upd_en with pc=0x100, taken, target=0x200 -> next cycle if_pc=0x100 gives pred_jump=1, pred_addr=0x200 (ctr=2). if_pc=0x104 gives pred_jump=0, pred_addr=0.
- From ctr=2 at 0x100:
  - two not-taken updates -> pred_jump=0 (ctr=0);
  - a third not-taken -> stays at 0;
  - then three taken updates -> ctr=3;
  - one not-taken -> ctr=2, pred_jump still 1.
- Aliasing: entry 0x100→0x200 valid. Lookup 0x140 (same index, different tag) -> pred_jump=0. Taken update 0x140→0x300 -> 0x140 predicts 0x300 and 0x100 now misses.
- Same-cycle update/lookup of 0x100 (not taken, ctr 2→1) -> that cycle pred_jump=1, next cycle 0.
- Clear pulse with valid entries -> busy=1 for 16 cycles, all lookups miss afterward. Reset asserted at sidx=7 -> sweep restarts, busy stays high 16 full cycles after release.
